fpu_addsub_pipe: RTL

- Parametrised, fully pipelined IEEE-754-style floating-point adder/subtractor.
- Generic exponent/fraction widths; default is bfloat16.
- Accepts packed operands and returns a rounded, packed result with exception flags. Rounding and unpacking are done internally.
- Sits in the FPU datapath between the operand-issue stage and the writeback arbiter. Uses valid/ready handshakes on both sides, so it tolerates writeback backpressure.

---
 rtl/fpu_addsub_pipe_pkg.sv | 39 +++
 rtl/fpu_lzc.sv | 23 ++
 rtl/fpu_addsub_pipe.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_addsub_pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fpu_addsub_pipe_pkg                                                        |
// | Shared FPU types: operand classes, exception flags, encoding helpers.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package fpu_addsub_pipe_pkg;

  typedef enum logic [2:0] {ZERO, DENORM, NORMAL, INF, QNAN, SNAN} fpClass_t;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
    logic zero;
  } fpFlags_t;

  // Canonical quiet NaN: positive, exponent all ones, fraction MSB set.
  function automatic logic [63:0] fpQnan(input int eDw, input int fDw);
    logic [63:0] v;
    v = ((64'd1 << eDw) - 64'd1) << fDw;
    v = v | (64'd1 << (fDw - 1));
    return v;
  endfunction

  function automatic logic [63:0] fpInf(input logic sign, input int eDw, input int fDw);
    logic [63:0] v;
    v = ((64'd1 << eDw) - 64'd1) << fDw;
    v = v | ({63'd0, sign} << (eDw + fDw));
    return v;
  endfunction

  function automatic logic rneInc(input logic lsb, input logic g, input logic r, input logic s);
    return g & (r | s | lsb);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_lzc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fpu_lzc                                                                    |
// | Leading-zero counter; an all-zero input returns WIDTH.                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fpu_lzc #(
  parameter int WIDTH = 12,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] i_data,
  output logic [CW-1:0]    o_count
);

  always_comb begin
    o_count = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (i_data[i]) o_count = CW'(WIDTH - 1 - i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fpu_addsub_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fpu_addsub_pipe                                                            |
// | 3-stage global-stall FP add/sub with RNE rounding and exception flags.     |
// | FPU_ADDSUB_DENORM_EN: honour denormals (else flush-to-zero).               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fpu_addsub_pipe
  import fpu_addsub_pipe_pkg::*;
#(
  parameter  int E_DW = 8,
  parameter  int F_DW = 7,
  localparam int W    = 1 + E_DW + F_DW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic         is_sub_i,
  input  logic [W-1:0] op1_i,
  input  logic [W-1:0] op2_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] res_o,
  output logic [4:0]   flags_o
);

  localparam int c_FW  = F_DW + 4;
  localparam int c_SW  = F_DW + 5;
  localparam int c_LZW = $clog2(c_SW + 1);
  localparam logic [E_DW-1:0] c_EMAX = '1;
  localparam logic [W-1:0]    c_QNAN = W'(fpQnan(E_DW, F_DW));
`ifdef FPU_ADDSUB_DENORM_EN
  localparam bit c_DENORM = 1'b1;
`else
  localparam bit c_DENORM = 1'b0;
`endif

  function automatic fpClass_t classify(input logic [E_DW-1:0] e, input logic [F_DW-1:0] f);
    if (e == '0) return (f == '0) ? ZERO : DENORM;
    if (e == c_EMAX) begin
      if (f == '0) return INF;
      return f[F_DW-1] ? QNAN : SNAN;
    end
    return NORMAL;
  endfunction

  // Returns {effective exponent, hidden bit, fraction} so magnitudes compare directly.
  function automatic logic [E_DW+F_DW:0] unpackMag(input fpClass_t c, input logic [E_DW-1:0] e,
                                                   input logic [F_DW-1:0] f);
    if (c == ZERO || (c == DENORM && !c_DENORM)) return '0;
    if (c == DENORM) return {E_DW'(1), 1'b0, f};
    return {e, 1'b1, f};
  endfunction

  logic w_stall;
  assign w_stall = valid_o & ~ready_i;
  assign ready_o = ~w_stall;

  // Stage 1: classify, swap, align
  fpClass_t            w_cls1, w_cls2;
  logic                w_sgn1, w_sgn2, w_swap, w_sgnL, w_sgnS;
  logic [E_DW+F_DW:0]  w_mag1, w_mag2, w_magL, w_magS;
  logic [E_DW:0]       w_diff, w_shAmt;
  logic [2*c_FW-1:0]   w_wide;
  logic [c_FW-1:0]     w_smallField;
  logic                w_spec, w_inv;
  logic [W-1:0]        w_specRes;

  always_comb begin
    w_cls1 = classify(op1_i[W-2:F_DW], op1_i[F_DW-1:0]);
    w_cls2 = classify(op2_i[W-2:F_DW], op2_i[F_DW-1:0]);
    w_sgn1 = op1_i[W-1];
    w_sgn2 = op2_i[W-1] ^ is_sub_i;
    w_mag1 = unpackMag(w_cls1, op1_i[W-2:F_DW], op1_i[F_DW-1:0]);
    w_mag2 = unpackMag(w_cls2, op2_i[W-2:F_DW], op2_i[F_DW-1:0]);
    w_swap = w_mag2 > w_mag1;
    w_magL = w_swap ? w_mag2 : w_mag1;
    w_magS = w_swap ? w_mag1 : w_mag2;
    w_sgnL = w_swap ? w_sgn2 : w_sgn1;
    w_sgnS = w_swap ? w_sgn1 : w_sgn2;
    w_diff = {1'b0, w_magL[E_DW+F_DW:F_DW+1]} - {1'b0, w_magS[E_DW+F_DW:F_DW+1]};
    w_shAmt = (w_diff > (E_DW+1)'(c_FW)) ? (E_DW+1)'(c_FW) : w_diff;
    w_wide = {w_magS[F_DW:0], 3'b000, {c_FW{1'b0}}} >> w_shAmt;
    w_smallField = w_wide[2*c_FW-1:c_FW] | {{(c_FW-1){1'b0}}, |w_wide[c_FW-1:0]};

    w_inv = (w_cls1 == SNAN) || (w_cls2 == SNAN) ||
            ((w_cls1 == INF) && (w_cls2 == INF) && (w_sgn1 != w_sgn2));
    w_spec = 1'b1;
    w_specRes = c_QNAN;
    if (w_inv || w_cls1 == QNAN || w_cls2 == QNAN) w_specRes = c_QNAN;
    else if (w_cls1 == INF) w_specRes = W'(fpInf(w_sgn1, E_DW, F_DW));
    else if (w_cls2 == INF) w_specRes = W'(fpInf(w_sgn2, E_DW, F_DW));
    else w_spec = 1'b0;
  end

  logic              r_s1Valid, r_s1SgnL, r_s1SgnS, r_s1Spec, r_s1Inv;
  logic [c_FW-1:0]   r_s1Large, r_s1Small;
  logic [E_DW-1:0]   r_s1Ex;
  logic [W-1:0]      r_s1SpecRes;

  // Stage 2: add/subtract and leading-zero count
  logic [c_SW-1:0]   w_sum;
  logic [c_LZW-1:0]  w_lzc;

  assign w_sum = (r_s1SgnL != r_s1SgnS) ? ({1'b0, r_s1Large} - {1'b0, r_s1Small})
                                        : ({1'b0, r_s1Large} + {1'b0, r_s1Small});

  fpu_lzc #(.WIDTH(c_SW), .CW(c_LZW)) u_lzc (
    .i_data  (w_sum),
    .o_count (w_lzc)
  );

  logic              r_s2Valid, r_s2Sgn, r_s2ZeroSgn, r_s2Spec, r_s2Inv;
  logic [c_SW-1:0]   r_s2Sum;
  logic [c_LZW-1:0]  r_s2Lzc;
  logic [E_DW-1:0]   r_s2Ex;
  logic [W-1:0]      r_s2SpecRes;

  // Stage 3: normalise, round, pack
  logic [c_FW-1:0]   w_norm;
  logic [E_DW:0]     w_exp;
  logic [E_DW-1:0]   w_expEnc;
  logic [W-2:0]      w_mag;
  logic              w_inexact, w_inc, w_tiny, w_ovf;
  int                w_lz, w_room, w_shift;
  logic [W-1:0]      w_res;
  fpFlags_t          w_flags;

  always_comb begin
    w_norm  = r_s2Sum[c_FW-1:0];
    w_exp   = {1'b0, r_s2Ex};
    w_lz    = 0;
    w_room  = 0;
    w_shift = 0;
    if (r_s2Sum[c_SW-1]) begin
      w_norm = {r_s2Sum[c_SW-1:2], r_s2Sum[1] | r_s2Sum[0]};
      w_exp  = w_exp + (E_DW+1)'(1);
    end else if (r_s2Sum != '0) begin
      // Stop normalising at exponent 1; whatever remains unnormalised is a denormal.
      w_lz    = int'(r_s2Lzc) - 1;
      w_room  = int'(r_s2Ex) - 1;
      w_shift = (w_lz < w_room) ? w_lz : w_room;
      w_norm  = w_norm << w_shift;
      w_exp   = w_exp - (E_DW+1)'(w_shift);
    end
    w_inexact = |w_norm[2:0];
    w_inc     = rneInc(w_norm[3], w_norm[2], w_norm[1], w_norm[0]);
    w_tiny    = ~w_norm[c_FW-1];
    w_expEnc  = w_tiny ? '0 : w_exp[E_DW-1:0];
    w_mag     = {w_expEnc, w_norm[c_FW-2:3]} + (W-1)'(w_inc);
    w_ovf     = (w_exp >= {1'b0, c_EMAX}) || (w_mag[W-2:F_DW] == c_EMAX);

    w_flags = '0;
    w_res   = {r_s2Sgn, w_mag};
    if (r_s2Spec) begin
      w_res = r_s2SpecRes;
      w_flags.invalid = r_s2Inv;
    end else if (r_s2Sum == '0) begin
      w_res = {r_s2ZeroSgn, {(W-1){1'b0}}};
      w_flags.zero = 1'b1;
    end else if (w_ovf) begin
      w_res = W'(fpInf(r_s2Sgn, E_DW, F_DW));
      w_flags.overflow = 1'b1;
      w_flags.inexact  = 1'b1;
    end else if (w_tiny && !c_DENORM) begin
      w_res = {r_s2Sgn, {(W-1){1'b0}}};
      w_flags.underflow = 1'b1;
      w_flags.inexact   = 1'b1;
      w_flags.zero      = 1'b1;
    end else begin
      w_flags.inexact   = w_inexact;
      w_flags.underflow = w_tiny & w_inexact;
      w_flags.zero      = (w_mag == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!w_stall) begin
      if (valid_i) begin
        r_s1Large   <= {w_magL[F_DW:0], 3'b000};
        r_s1Small   <= w_smallField;
        r_s1Ex      <= w_magL[E_DW+F_DW:F_DW+1];
        r_s1SgnL    <= w_sgnL;
        r_s1SgnS    <= w_sgnS;
        r_s1Spec    <= w_spec;
        r_s1Inv     <= w_inv;
        r_s1SpecRes <= w_specRes;
      end
      if (r_s1Valid) begin
        r_s2Sum     <= w_sum;
        r_s2Lzc     <= w_lzc;
        r_s2Ex      <= r_s1Ex;
        r_s2Sgn     <= r_s1SgnL;
        r_s2ZeroSgn <= r_s1SgnL & r_s1SgnS;
        r_s2Spec    <= r_s1Spec;
        r_s2Inv     <= r_s1Inv;
        r_s2SpecRes <= r_s1SpecRes;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1Valid <= 1'b0;
      r_s2Valid <= 1'b0;
      valid_o   <= 1'b0;
      res_o     <= '0;
      flags_o   <= '0;
    end else if (!w_stall) begin
      r_s1Valid <= valid_i;
      r_s2Valid <= r_s1Valid;
      valid_o   <= r_s2Valid;
      if (r_s2Valid) begin
        res_o   <= w_res;
        flags_o <= w_flags;
      end
    end
  end

endmodule
`default_nettype wire
